// File: rtl/modulo_acumulador.sv
// Saturating accumulator for the 8-bit multiplier's {overflow, produto} words.
// It sums N_TERMOS products per operation and holds the result until it is consumed.
module modulo_acumulador #(
  parameter int N_TERMOS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       limpar,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_resultado,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_soma,
  output logic       out_overflow,
  output logic [7:0] parcial,
  output logic [7:0] contagem
);

  typedef enum logic {ACUM, SAIDA} estado_t;

  localparam logic [7:0] ULTIMO = 8'(N_TERMOS - 1);

  estado_t    estado;
  logic       sticky;
  logic [8:0] soma9;
  logic       sat;
  logic [7:0] proximo;
  logic       aceita;

  // Once saturated, the running sum stays pinned at 8'hFF for the rest of the operation.
  assign soma9   = {1'b0, parcial} + {1'b0, in_resultado[7:0]};
  assign sat     = soma9[8] | in_resultado[8] | sticky;
  assign proximo = sat ? 8'hFF : soma9[7:0];

  assign in_ready  = (estado == ACUM) & ~limpar;
  assign out_valid = (estado == SAIDA);
  assign aceita    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst || limpar) begin
      estado       <= ACUM;
      parcial      <= 8'h00;
      contagem     <= 8'h00;
      sticky       <= 1'b0;
      out_soma     <= 8'h00;
      out_overflow <= 1'b0;
    end else begin
      case (estado)
        ACUM: begin
          if (aceita) begin
            parcial  <= proximo;
            sticky   <= sat;
            contagem <= contagem + 8'd1;
            if (contagem == ULTIMO) begin
              out_soma     <= proximo;
              out_overflow <= sat;
              estado       <= SAIDA;
            end
          end
        end
        SAIDA: begin
          // The finished result stays on out_soma/out_overflow after it is taken.
          if (out_ready) begin
            parcial  <= 8'h00;
            contagem <= 8'h00;
            sticky   <= 1'b0;
            estado   <= ACUM;
          end
        end
        default: estado <= ACUM;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_acumulador.sv
// Self-checking bench: an N=4 and an N=1 accumulator checked every cycle
// against an arithmetic model, plus hand-computed literal checks.
module tb_modulo_acumulador;

  logic       clk = 1'b0;
  logic       rst;
  logic       limpar    [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [8:0] in_res    [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_soma  [2];
  logic       out_ovf   [2];
  logic [7:0] parcial   [2];
  logic [7:0] contagem  [2];

  int  total = 0;
  int  bad = 0;
  bit  checking = 1'b0;

  int       ntermos [2] = '{4, 1};
  int       m_cnt   [2];
  int       m_total [2];
  bit       m_ovf   [2];
  bit       m_busy  [2];
  bit [7:0] m_soma  [2];
  bit       m_sovf  [2];

  always #5 clk = ~clk;

  modulo_acumulador #(.N_TERMOS(4)) dut (
    .clk(clk), .rst(rst), .limpar(limpar[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_resultado(in_res[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_soma(out_soma[0]), .out_overflow(out_ovf[0]),
    .parcial(parcial[0]), .contagem(contagem[0])
  );

  modulo_acumulador #(.N_TERMOS(1)) dut1 (
    .clk(clk), .rst(rst), .limpar(limpar[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_resultado(in_res[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_soma(out_soma[1]), .out_overflow(out_ovf[1]),
    .parcial(parcial[1]), .contagem(contagem[1])
  );

  // Saturated value of a sum of products: any flagged term or a total above 255 pins it at 255.
  function automatic bit [7:0] satsum(input int t, input bit o);
    bit [31:0] tv;
    tv = t;
    return (o || t > 255) ? 8'hFF : tv[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [8:0] d,
                               input logic ordy, input logic lim);
    in_valid[k]  = v;
    in_res[k]    = d;
    out_ready[k] = ordy;
    limpar[k]    = lim;
    @(posedge clk);
    #1;
  endtask

  // Model: tracks the products accepted in the current operation as a plain total.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || limpar[k]) begin
        m_cnt[k] = 0; m_total[k] = 0; m_ovf[k] = 1'b0; m_busy[k] = 1'b0;
        m_soma[k] = 8'h00; m_sovf[k] = 1'b0;
      end else if (!m_busy[k] && in_valid[k]) begin
        m_cnt[k]++;
        m_total[k] += int'(in_res[k][7:0]);
        m_ovf[k] = m_ovf[k] | in_res[k][8];
        if (m_cnt[k] == ntermos[k]) begin
          m_busy[k] = 1'b1;
          m_soma[k] = satsum(m_total[k], m_ovf[k]);
          m_sovf[k] = m_ovf[k] || (m_total[k] > 255);
        end
      end else if (m_busy[k] && out_ready[k]) begin
        m_busy[k] = 1'b0; m_cnt[k] = 0; m_total[k] = 0; m_ovf[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("in_ready[%0d]", k), {7'd0, in_ready[k]},
                    {7'd0, !m_busy[k] && !limpar[k]});
        checkOutput($sformatf("out_valid[%0d]", k), {7'd0, out_valid[k]}, {7'd0, m_busy[k]});
        checkOutput($sformatf("parcial[%0d]", k), parcial[k], satsum(m_total[k], m_ovf[k]));
        checkOutput($sformatf("contagem[%0d]", k), contagem[k], 8'(m_cnt[k]));
        checkOutput($sformatf("out_soma[%0d]", k), out_soma[k], m_soma[k]);
        checkOutput($sformatf("out_overflow[%0d]", k), {7'd0, out_ovf[k]}, {7'd0, m_sovf[k]});
      end
    end
  end

  logic [8:0] t1 [4] = '{9'h005, 9'h00A, 9'h003, 9'h001};
  logic [8:0] t2 [4] = '{9'h0F0, 9'h020, 9'h001, 9'h001};
  logic [8:0] t3 [4] = '{9'h001, 9'h102, 9'h003, 9'h004};
  logic [8:0] t4 [4] = '{9'h001, 9'h002, 9'h003, 9'h004};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      limpar[k] = 1'b0; in_valid[k] = 1'b0; in_res[k] = 9'h000; out_ready[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    checking = 1'b1;
    applyStimulus(0, 1'b0, 9'h000, 1'b0, 1'b0);
    checkOutput("reset out_valid", {7'd0, out_valid[0]}, 8'h00);
    checkOutput("reset out_soma", out_soma[0], 8'h00);
    checkOutput("reset contagem", contagem[0], 8'h00);
    rst = 1'b0;

    $display("[TB] simple dot product");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, t1[i], 1'b1, 1'b0);
    checkOutput("t1 out_valid", {7'd0, out_valid[0]}, 8'h01);
    checkOutput("t1 in_ready", {7'd0, in_ready[0]}, 8'h00);
    checkOutput("t1 out_soma", out_soma[0], 8'h13);
    checkOutput("t1 out_overflow", {7'd0, out_ovf[0]}, 8'h00);
    applyStimulus(0, 1'b0, 9'h000, 1'b1, 1'b0);

    $display("[TB] carry saturation");
    applyStimulus(0, 1'b1, t2[0], 1'b1, 1'b0);
    applyStimulus(0, 1'b1, t2[1], 1'b1, 1'b0);
    checkOutput("t2 parcial after carry", parcial[0], 8'hFF);
    applyStimulus(0, 1'b1, t2[2], 1'b1, 1'b0);
    applyStimulus(0, 1'b1, t2[3], 1'b1, 1'b0);
    checkOutput("t2 out_soma", out_soma[0], 8'hFF);
    checkOutput("t2 out_overflow", {7'd0, out_ovf[0]}, 8'h01);
    applyStimulus(0, 1'b0, 9'h000, 1'b1, 1'b0);

    $display("[TB] multiplier overflow bit");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, t3[i], 1'b1, 1'b0);
    checkOutput("t3 out_soma", out_soma[0], 8'hFF);
    checkOutput("t3 out_overflow", {7'd0, out_ovf[0]}, 8'h01);
    applyStimulus(0, 1'b0, 9'h000, 1'b1, 1'b0);

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, t4[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 9'h055, 1'b0, 1'b0);
    checkOutput("t4 held contagem", contagem[0], 8'h04);
    checkOutput("t4 held out_soma", out_soma[0], 8'h0A);
    applyStimulus(0, 1'b0, 9'h000, 1'b1, 1'b0);
    checkOutput("t4 restart contagem", contagem[0], 8'h00);
    checkOutput("t4 restart parcial", parcial[0], 8'h00);
    checkOutput("t4 kept out_soma", out_soma[0], 8'h0A);
    applyStimulus(0, 1'b1, 9'h007, 1'b1, 1'b0);
    checkOutput("t4 first of next op", parcial[0], 8'h07);

    $display("[TB] limpar and reset");
    applyStimulus(0, 1'b1, 9'h003, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 9'h000, 1'b1, 1'b1);
    checkOutput("t5 limpar contagem", contagem[0], 8'h00);
    checkOutput("t5 limpar parcial", parcial[0], 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, t1[i], 1'b0, 1'b0);
    checkOutput("t5 pending valid", {7'd0, out_valid[0]}, 8'h01);
    applyStimulus(0, 1'b0, 9'h000, 1'b0, 1'b1);
    checkOutput("t5 dropped valid", {7'd0, out_valid[0]}, 8'h00);
    checkOutput("t5 dropped out_soma", out_soma[0], 8'h00);
    applyStimulus(0, 1'b1, 9'h011, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 9'h022, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(0, 1'b1, 9'h033, 1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("t5 rst parcial", parcial[0], 8'h00);
    checkOutput("t5 rst contagem", contagem[0], 8'h00);
    applyStimulus(0, 1'b0, 9'h000, 1'b0, 1'b0);

    $display("[TB] single-term stream");
    applyStimulus(1, 1'b1, 9'h0C4, 1'b1, 1'b0);
    checkOutput("t6 single out_soma", out_soma[1], 8'hC4);
    for (int i = 0; i < 24; i++)
      applyStimulus(1, 1'b1, 9'($urandom_range(0, 511)), 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 9'h000, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 9'h000, 1'b1, 1'b0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
